dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the exec stage's Load/Store requests.
//  - Accepts one request per handshake and drives a synchronous BRAM port.
//  - Returns Load data, with its target register, to writeback.
//  - Raises memory_used while a Load is in flight so the fetch/decode/exec stall logic can hold non-memory instructions.
// PARAMETERS
//  ADDR_W   15  word-address width into BRAM; upper request address bits ignored
//  DATA_W   32  data width, signed GPR word
//  RT_W     5   destination register index width
//  RD_LAT   2   BRAM read latency, cycles from bram_en to valid bram_dout; legal range 1..7
// PORTS
//  clk          in   1       rising-edge clock
//  rstn         in   1       asynchronous active-low reset
//  req_valid    in   1       exec presents a memory request
//  req_ready    out  1       responder can accept a request this cycle
//  req_op       in   2       01 Load, 10 Store, 00/11 no-op
//  req_addr     in   32      word address
//  req_wdata    in   DATA_W  Store data
//  req_rt       in   RT_W    Load destination register
//  memory_used  out  1       a Load is outstanding (stall hint to pipeline)
//  bram_en      out  1       BRAM port enable
//  bram_we      out  1       BRAM write enable
//  bram_addr    out  ADDR_W  BRAM address
//  bram_din     out  DATA_W  BRAM write data
//  bram_dout    in   DATA_W  BRAM read data
//  wb_valid     out  1       one-cycle Load-result strobe to writeback
//  wb_tdata     out  DATA_W  Load result
//  wb_rt        out  RT_W    Load destination register
//  wb_rt_flag   out  1       write-enable for writeback; equals wb_valid
// BEHAVIOUR
//  - Handshake: request accepted when req_valid & req_ready in the same cycle (cycle N).
//  - BRAM outputs are combinational from the accepted request; everything else is registered.
//  - FSM IDLE / WAIT / RESP:
//    - IDLE: req_ready=1.
//      - Store accepted: bram_en=bram_we=1, addr/din driven in cycle N; state stays IDLE.
//        Back-to-back Stores are sustained at 1 per cycle.
//      - Load accepted: bram_en=1, bram_we=0 in cycle N; latency counter loads RD_LAT; go to WAIT.
//      - No-op accepted: nothing is driven to BRAM; unsupported_cnt increments.
//    - WAIT: req_ready=0, memory_used=1; counter decrements each cycle.
//      When it reaches 1, bram_dout is captured into wb_tdata; go to RESP.
//    - RESP: wb_valid=wb_rt_flag=1 for exactly one cycle (cycle N+RD_LAT+1); memory_used=1; req_ready=1.
//      A request accepted in RESP is handled as in IDLE.
//      Next state: WAIT if the accepted request is a Load; otherwise IDLE.
//  - Load latency to wb_valid: RD_LAT+1 cycles. Load-to-Load throughput: one every RD_LAT+1 cycles.
//  - Address truncation: req_addr[ADDR_W-1:0] is used; no wrap detection.
//  - Reset (async, any state):
//    - state=IDLE; wb_valid, wb_rt_flag, memory_used = 0; wb_tdata, wb_rt = 0; unsupported_cnt = 0.
//    - An in-flight Load is dropped with no wb_valid.
//    - req_ready=1 from the first cycle after rstn deasserts.
// CONFIGURATION
//  MEM_RAW_FWD_EN defined:
//    - A last-store register (valid, addr, data) is updated on every accepted Store.
//    - A Load whose truncated address matches it returns the register data, not bram_dout; latency unchanged.
//    - BRAM may then be read-first.
//  MEM_RAW_FWD_EN undefined: no register; Load data always comes from bram_dout; BRAM must be write-first.
// STRUCTURE
//  - Package dmem_pkg: op enum (OP_NONE, OP_LOAD, OP_STORE); state enum.
//    Also opcode constants OPC_LOAD=6'b010000 and OPC_STORE=6'b010001 for the exec-side op decode.
//  - Sub-module dmem_fwd_reg: last-store register and address compare; instantiated only under MEM_RAW_FWD_EN.
//  - unsupported_cnt: internal 8-bit saturating counter, debug only.
// TESTING
//  - Store 0x0000_00AB to addr 5, then Load addr 5 into rt 3 with RD_LAT=2
//    -> wb_valid one cycle at N+3, wb_tdata=0xAB, wb_rt=3.
//  - Ten back-to-back Stores -> req_ready stays 1; bram_we high for 10 consecutive cycles.
//  - Load then immediate Load -> req_ready=0 during WAIT; second Load is accepted in the RESP cycle.
//    Two wb_valid pulses 3 cycles apart.
//  - Load with req_addr=0x0001_8004, ADDR_W=15 -> bram_addr=0x0004.
//  - rstn pulsed low while in WAIT -> no wb_valid; memory_used=0 immediately; next Load completes normally.
//  - MEM_RAW_FWD_EN, read-first BRAM model: Store 0x55 to addr 9, Load addr 9 next cycle -> wb_tdata=0x55.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Op and state encodings plus exec-side opcode constants.
package dmem_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [5:0] OPC_LOAD  = 6'b010000;
  localparam logic [5:0] OPC_STORE = 6'b010001;

  localparam int CNT_W = 3;

  function automatic op_e decode_op(
    input logic [1:0] raw
  );
    unique case (raw)
      2'b01:   return OP_LOAD;
      2'b10:   return OP_STORE;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Exec-to-memory request bus plus the writeback result strobe.
// master = exec/writeback side, slave = dmem_responder.
interface dmem_responder_if #(
    parameter int DATA_W = 32,
    parameter int RT_W   = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RT_W-1:0]   req_rt;
    logic              memory_used;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_tdata;
    logic [RT_W-1:0]   wb_rt;
    logic              wb_rt_flag;

    modport master (
        output req_valid, req_op, req_addr,
        output req_wdata, req_rt,
        input  req_ready, memory_used,
        input  wb_valid, wb_tdata, wb_rt, wb_rt_flag
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        input  req_wdata, req_rt,
        output req_ready, memory_used,
        output wb_valid, wb_tdata, wb_rt, wb_rt_flag
    );
endinterface

// File: rtl/dmem_fwd_reg.sv
// Last-store register with load-address compare.
// Lets a read-first BRAM still return freshly stored data.
module dmem_fwd_reg
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (st_en) begin
            valid_q <= 1'b1;
            addr_q  <= st_addr;
            data_q  <= st_data;
        end
    end

    assign hit  = valid_q && (addr_q == ld_addr);
    assign data = data_q;
endmodule

// File: rtl/dmem_responder.sv
// Load/Store responder driving a synchronous BRAM port.
// Optional MEM_RAW_FWD_EN: forward last store to a matching load.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RT_W   = 5,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_responder_if.slave   bus,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op;
    logic              accept, ld_acc, st_acc, nop_acc;
    logic              capture;
    logic              mem_used_q, wb_valid_q;
    logic [DATA_W-1:0] wb_tdata_q, ld_data;
    logic [RT_W-1:0]   wb_rt_q, rt_q;
    logic [7:0]        unsupported_cnt;
    logic              unused_addr_hi;

    assign op      = decode_op(bus.req_op);
    assign accept  = bus.req_valid && bus.req_ready;
    assign ld_acc  = accept && (op == OP_LOAD);
    assign st_acc  = accept && (op == OP_STORE);
    assign nop_acc = accept && (op == OP_NONE);
    assign capture = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));

    assign bram_en   = ld_acc || st_acc;
    assign bram_we   = st_acc;
    assign bram_addr = bus.req_addr[ADDR_W-1:0];
    assign bram_din  = bus.req_wdata;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    assign bus.req_ready   = (state_q != S_WAIT);
    assign bus.memory_used = mem_used_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rt_flag  = wb_valid_q;
    assign bus.wb_tdata    = wb_tdata_q;
    assign bus.wb_rt       = wb_rt_q;

`ifdef MEM_RAW_FWD_EN
    logic              fwd_hit, hit_q;
    logic [DATA_W-1:0] fwd_data, fwd_q;

    dmem_fwd_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .clk     (clk),
        .rstn    (rstn),
        .st_en   (st_acc),
        .st_addr (bram_addr),
        .st_data (bus.req_wdata),
        .ld_addr (bram_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_q <= 1'b0;
            fwd_q <= '0;
        end else if (ld_acc) begin
            hit_q <= fwd_hit;
            fwd_q <= fwd_data;
        end
    end

    assign ld_data = hit_q ? fwd_q : bram_dout;
`else
    assign ld_data = bram_dout;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (ld_acc) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (capture) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_used_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_tdata_q <= '0;
            wb_rt_q    <= '0;
            rt_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_used_q <= (state_d != S_IDLE);
            wb_valid_q <= capture;
            if (ld_acc) rt_q <= bus.req_rt;
            if (capture) begin
                wb_tdata_q <= ld_data;
                wb_rt_q    <= rt_q;
            end
        end
    end

    // Debug-only count of no-op requests, saturates at 255.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            unsupported_cnt <= '0;
        end else if (nop_acc && unsupported_cnt != 8'hFF) begin
            unsupported_cnt <= unsupported_cnt + 8'd1;
        end
    end
endmodule
